// File: rtl/cdc_pkg.sv
// Shared types and constants for the req/ack clock-domain-crossing blocks.
package cdc_pkg;

  // Source-side handshake states: waiting, request raised, request released.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } cdc_hs_tx_state_e;

  // Fewer than two flops does not give a metastable ack time to settle.
  localparam int CDC_MIN_LEVELS = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer bringing an asynchronous level into wclk_i.
module cdc_sync_bit #(
  parameter int LEVELS = 2
) (
  input  logic wclk_i,
  input  logic warst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [LEVELS-1:0] sync_q;

  // Shift the asynchronous input through the flop chain; oldest bit is the output.
  always_ff @(posedge wclk_i or negedge warst_ni) begin
    if (!warst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[LEVELS-2:0], d_i};
    end
  end

  assign q_o = sync_q[LEVELS-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-domain transmitter of a four-phase req/ack handshake with a
// one-entry pending buffer so the producer can run ahead by one word.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int LEVELS = 2,
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 16
) (
  input  logic             wclk_i,
  input  logic             warst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_i,
  output logic             done_o,
  output logic [CNT_W-1:0] tx_count_o
);

  if (LEVELS < CDC_MIN_LEVELS) begin : g_levels_check
    $error("cdc_hs_tx: LEVELS must be at least CDC_MIN_LEVELS");
  end

  cdc_hs_tx_state_e state_q;
  logic             req_q;
  logic [WIDTH-1:0] data_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pend_q;
  logic [WIDTH-1:0] pend_data_q;
  logic             ack_s;

  logic             accept;
  logic             avail;
  logic             launch;
  logic             bypass;
  logic [WIDTH-1:0] launch_word;

  cdc_sync_bit #(
    .LEVELS (LEVELS)
  ) u_ack_sync (
    .wclk_i   (wclk_i),
    .warst_ni (warst_ni),
    .d_i      (ack_i),
    .q_o      (ack_s)
  );

  assign ready_o     = ~pend_q;
  assign accept      = valid_i & ~pend_q;
  assign avail       = pend_q | accept;
  // The pending word is always older than a same-cycle accept, so it goes first.
  assign launch_word = pend_q ? pend_data_q : data_i;
  assign bypass      = launch & ~pend_q;

  // Decide whether a new word goes out this cycle; only from IDLE or end of REL,
  // and never while the destination still shows an acknowledge.
  always_comb begin
    launch = 1'b0;
    case (state_q)
      IDLE:    launch = ~ack_s & avail;
      REL:     launch = ~ack_s & avail;
      default: launch = 1'b0;
    endcase
  end

  // Handshake FSM with registered req, data, done and transfer counter.
  always_ff @(posedge wclk_i or negedge warst_ni) begin
    if (!warst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            data_q  <= launch_word;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= REL;
          end
        end
        REL: begin
          if (!ack_s) begin
            done_q <= 1'b1;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (launch) begin
              data_q  <= launch_word;
              req_q   <= 1'b1;
              state_q <= REQ;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // One-entry pending buffer: fill on any accept not bypassed straight to
  // data_o, empty when its word is launched.
  always_ff @(posedge wclk_i or negedge warst_ni) begin
    if (!warst_ni) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else begin
      if (accept && !bypass) begin
        pend_q      <= 1'b1;
        pend_data_q <= data_i;
      end else if (launch) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign req_o      = req_q;
  assign data_o     = data_q;
  assign done_o     = done_q;
  assign tx_count_o = cnt_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed and randomized bench for cdc_hs_tx with a modelled destination.
module tb_cdc_hs_tx;

  logic        wclk_i;
  logic        warst_ni;
  logic        valid_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        req_o;
  logic [31:0] data_o;
  logic        ack_i;
  logic        done_o;
  logic [3:0]  tx_count_o;

  int n_chk;
  int n_bad;

  logic [31:0] exp_q[$];
  logic        done_req_q[$];
  int          done_cnt;
  int          viol_stab;
  int          viol_rise;
  bit          dest_auto;
  bit          rand_mode;

  logic [1:0]  m_sync;
  logic        prev_req;
  logic [31:0] prev_data;
  logic        prev_ack;

  cdc_hs_tx #(
    .LEVELS (2),
    .WIDTH  (32),
    .CNT_W  (4)
  ) dut (
    .wclk_i     (wclk_i),
    .warst_ni   (warst_ni),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .req_o      (req_o),
    .data_o     (data_o),
    .ack_i      (ack_i),
    .done_o     (done_o),
    .tx_count_o (tx_count_o)
  );

  initial wclk_i = 1'b0;
  always #5 wclk_i = ~wclk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk_i);
    #1;
  endtask

  // Offer one word and wait until it is accepted; valid_i is left high.
  task automatic send(input logic [31:0] w);
    logic acc;
    valid_i = 1'b1;
    data_i  = w;
    for (int k = 0; k < 400; k++) begin
      acc = ready_o;
      tick();
      if (acc) begin
        exp_q.push_back(w);
        $display("send %08h accepted", w);
        return;
      end
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  // Wait until every queued word has completed its four phases.
  task automatic drain();
    for (int k = 0; k < 5000; k++) begin
      if (exp_q.size() == 0 && !req_o && !ack_i) begin
        repeat (5) tick();
        return;
      end
      tick();
    end
    check("drain_timeout", 32'd1, 32'd0);
  endtask

  // Reference two-flop ack synchronizer used by the protocol monitor.
  always @(posedge wclk_i or negedge warst_ni) begin
    if (!warst_ni) m_sync <= 2'b00;
    else           m_sync <= {m_sync[0], ack_i};
  end

  // Destination model: follow req_o after a delay, capturing data_o when acking.
  initial begin
    int cnt;
    int dly;
    logic [31:0] w;
    cnt   = 0;
    dly   = 3;
    ack_i = 1'b0;
    forever begin
      @(posedge wclk_i);
      #2;
      if (!dest_auto) begin
        cnt = 0;
      end else if (req_o !== ack_i) begin
        if (cnt >= dly) begin
          if (req_o) begin
            if (exp_q.size() == 0) begin
              check("sb_unexpected", 32'd1, 32'd0);
            end else begin
              w = exp_q.pop_front();
              check("sb_data", data_o, w);
              $display("capture %08h expect %08h", data_o, w);
            end
          end
          ack_i = req_o;
          cnt   = 0;
          dly   = rand_mode ? int'($urandom_range(0, 20)) : 3;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Protocol monitor: data stability during req, no req rise while ack is seen.
  initial begin
    prev_req  = 1'b0;
    prev_data = '0;
    prev_ack  = 1'b0;
    forever begin
      @(posedge wclk_i);
      #3;
      if (warst_ni) begin
        if (prev_req && req_o && data_o !== prev_data) viol_stab++;
        if (!prev_req && req_o && prev_ack) viol_rise++;
        if (done_o) begin
          done_cnt++;
          done_req_q.push_back(req_o);
        end
      end
      prev_req  = req_o;
      prev_data = data_o;
      prev_ack  = m_sync[1];
    end
  end

  initial begin
    int bad_hold;
    bit seen;
    n_chk     = 0;
    n_bad     = 0;
    done_cnt  = 0;
    viol_stab = 0;
    viol_rise = 0;
    dest_auto = 1'b0;
    rand_mode = 1'b0;
    warst_ni  = 1'b0;
    valid_i   = 1'b0;
    data_i    = '0;
    repeat (3) tick();
    warst_ni = 1'b1;
    tick();

    // Reset state
    check("rst_ready", ready_o, 1);
    check("rst_req", req_o, 0);
    check("rst_data", data_o, 0);
    check("rst_count", tx_count_o, 0);
    check("rst_done", done_o, 0);

    // Single word with bypass launch
    dest_auto = 1'b1;
    send(32'hDEADBEEF);
    valid_i = 1'b0;
    check("single_req", req_o, 1);
    check("single_data", data_o, 32'hDEADBEEF);
    bad_hold = 0;
    seen     = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      if (done_o) seen = 1'b1;
      else if (data_o !== 32'hDEADBEEF) bad_hold++;
    end
    check("single_done_seen", seen, 1);
    check("single_hold", bad_hold, 0);
    check("single_count", tx_count_o, 1);
    repeat (3) tick();
    check("single_done_cnt", done_cnt, 1);

    // Pending buffer and back-to-back launches
    done_req_q.delete();
    send(32'h1);
    send(32'h2);
    check("pend_ready", ready_o, 0);
    check("pend_data1", data_o, 32'h1);
    send(32'h3);
    valid_i = 1'b0;
    check("pend_holdoff", data_o, 32'h2);
    drain();
    check("pend_done_n", done_req_q.size(), 3);
    if (done_req_q.size() == 3) begin
      check("pend_b2b_1", done_req_q[0], 1);
      check("pend_b2b_2", done_req_q[1], 1);
      check("pend_b2b_3", done_req_q[2], 0);
    end
    check("pend_count", tx_count_o, 4);

    // Stale ack across a reset
    dest_auto = 1'b0;
    valid_i   = 1'b1;
    data_i    = 32'hAA;
    tick();
    valid_i = 1'b0;
    check("stale_req_up", req_o, 1);
    ack_i = 1'b1;
    tick();
    warst_ni = 1'b0;
    #1;
    check("stale_rst_req", req_o, 0);
    check("stale_rst_data", data_o, 0);
    tick();
    tick();
    warst_ni = 1'b1;
    done_cnt = 0;
    done_req_q.delete();
    repeat (4) tick();
    check("stale_ready0", ready_o, 1);
    valid_i = 1'b1;
    data_i  = 32'h55;
    tick();
    valid_i = 1'b0;
    exp_q.push_back(32'h55);
    check("stale_pend", ready_o, 0);
    check("stale_req0", req_o, 0);
    repeat (3) tick();
    check("stale_req_wait", req_o, 0);
    ack_i = 1'b0;
    tick();
    check("stale_req_l1", req_o, 0);
    tick();
    check("stale_req_l2", req_o, 0);
    tick();
    check("stale_req_rise", req_o, 1);
    check("stale_data", data_o, 32'h55);
    dest_auto = 1'b1;
    drain();
    check("stale_count", tx_count_o, 1);

    // Counter wrap: fifteen more transfers reach sixteen
    for (int i = 0; i < 15; i++) send(32'h100 + i);
    valid_i = 1'b0;
    drain();
    check("wrap_done_cnt", done_cnt, 16);
    check("wrap_count", tx_count_o, 0);

    // Random producer gaps and destination delays
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      valid_i = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      send($urandom);
    end
    valid_i = 1'b0;
    drain();
    check("rand_done_cnt", done_cnt, 1016);
    check("rand_count", tx_count_o, 8);
    check("rand_sb_empty", exp_q.size(), 0);
    check("mon_stable", viol_stab, 0);
    check("mon_no_rise_on_ack", viol_rise, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
